alu_sequencer: RTL and testbench

// Microcode sequencer on the control side of the line-follower ALU. Each go it reads six IR channels over the A2D

---
 rtl/line_follower_pkg.sv | 83 ++++++++
 rtl/alu_sequencer_if.sv | 45 ++++
 rtl/alu_sequencer_settle_timer.sv | 33 +++
 rtl/alu_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_follower_pkg.sv
// Shared types and constants for the line-follower control sequencer.
// No logic; pure typedefs, select codes, channel map and flag bit positions.
// No handshake of its own; consumed by alu_sequencer and its interface users.
package line_follower_pkg;

    // Sequencer states, in the order a go normally walks through them.
    typedef enum logic [3:0] {
        S_IDLE,
        S_SETTLE,
        S_CONV,
        S_WAIT,
        S_ACC,
        S_INTG,
        S_ICMP,
        S_PCMP,
        S_RHT1,
        S_RHT2,
        S_LFT1,
        S_LFT2,
        S_DONE
    } state_t;

    // Which register captures dst at the end of the current ALU state.
    typedef enum logic [2:0] {
        CAP_NONE,
        CAP_ACCUM,
        CAP_ERROR,
        CAP_INTGRL,
        CAP_ICOMP,
        CAP_PCOMP,
        CAP_RHT,
        CAP_LFT
    } cap_t;

    // ALU src1 select codes
    localparam logic [2:0] SRC1_ACCUM  = 3'd0;
    localparam logic [2:0] SRC1_ITERM  = 3'd1;
    localparam logic [2:0] SRC1_ERROR  = 3'd2;
    localparam logic [2:0] SRC1_ERRSH4 = 3'd3;
    localparam logic [2:0] SRC1_FWD    = 3'd4;
    localparam logic [2:0] SRC1_ZERO   = 3'd7;

    // ALU src0 select codes
    localparam logic [2:0] SRC0_A2D    = 3'd0;
    localparam logic [2:0] SRC0_INTGRL = 3'd1;
    localparam logic [2:0] SRC0_ICOMP  = 3'd2;
    localparam logic [2:0] SRC0_PCOMP  = 3'd3;
    localparam logic [2:0] SRC0_PTERM  = 3'd4;
    localparam logic [2:0] SRC0_ZERO   = 3'd7;

    // Bit positions inside the packed ALU op-flag vector
    localparam int FLG_MULTIPLY = 0;
    localparam int FLG_SUB      = 1;
    localparam int FLG_MULT2    = 2;
    localparam int FLG_MULT4    = 3;
    localparam int FLG_SAT      = 4;
    localparam int NUM_FLAGS    = 5;

    // Sensor index of the last IR pair; its ACC step produces Error.
    localparam logic [2:0] LAST_IDX = 3'd5;

    // One ALU control word: operand selects, op flags and capture target.
    typedef struct packed {
        logic [2:0]           src1sel;
        logic [2:0]           src0sel;
        logic [NUM_FLAGS-1:0] flags;
        cap_t                 cap;
    } ctrl_t;

    // Sensor index -> A2D channel. Sensors are not wired in channel order.
    function automatic logic [2:0] chnl_map(input logic [2:0] idx);
        case (idx)
            3'd0:    chnl_map = 3'd1;
            3'd1:    chnl_map = 3'd0;
            3'd2:    chnl_map = 3'd4;
            3'd3:    chnl_map = 3'd2;
            3'd4:    chnl_map = 3'd3;
            3'd5:    chnl_map = 3'd7;
            default: chnl_map = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle between the sequencer and its ALU / A2D neighbours.
// Wires only, no latency.
// go/cnv_cmplt are plain strobes; there is no backpressure on this bus.
// Ports: go, cnv_cmplt, dst into the sequencer; A2D controls, ALU selects/flags,
//        working registers, motor drive and busy/done out of it.
interface alu_sequencer_if;
    logic        go;
    logic        cnv_cmplt;
    logic [15:0] dst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        ir_en;
    logic [2:0]  src1sel;
    logic [2:0]  src0sel;
    logic        multiply;
    logic        sub;
    logic        mult2;
    logic        mult4;
    logic        saturate;
    logic [15:0] Accum;
    logic [11:0] Error;
    logic [11:0] Intgrl;
    logic [11:0] Icomp;
    logic [15:0] Pcomp;
    logic [11:0] lft;
    logic [11:0] rht;
    logic        busy;
    logic        done;

    // Sequencer side
    modport master (
        input  go, cnv_cmplt, dst,
        output strt_cnv, chnnl, ir_en, src1sel, src0sel,
               multiply, sub, mult2, mult4, saturate,
               Accum, Error, Intgrl, Icomp, Pcomp, lft, rht, busy, done
    );

    // Environment side (ALU, A2D, go source)
    modport slave (
        output go, cnv_cmplt, dst,
        input  strt_cnv, chnnl, ir_en, src1sel, src0sel,
               multiply, sub, mult2, mult4, saturate,
               Accum, Error, Intgrl, Icomp, Pcomp, lft, rht, busy, done
    );
endinterface

// File: rtl/alu_sequencer_settle_timer.sv
// IR emitter settle timer: load, count down, flag expiry.
// expired is combinational from the count; reaches 0 CYCLES-1 enables after load.
// No handshake; caller decides when to load and enable.
// Ports: clk, rst (sync, active high), load, en, expired.
module ir_settle_timer #(
    parameter int CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    // Loading CYCLES-1 makes the SETTLE state last exactly CYCLES cycles,
    // since the final cycle is the one where the count reads zero.
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Microcode sequencer: 6-channel IR read, weighted Error, PI update, lft/rht drive.
// go->done = 1 + SETTLE_CYCLES + 6*(CONV+WAIT+ACC) + 7 cycles (6 when INTG skipped).
// go ignored while busy; waits indefinitely in WAIT for cnv_cmplt.
// Ports: clk, rst (sync, active high); bus (master modport) carries go, A2D
//        handshake, ALU selects/flags, dst and all result registers.
module alu_sequencer
    import line_follower_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4096,
    parameter int INTGRL_DIV    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_sequencer_if.master        bus
);
    localparam int             IW       = (INTGRL_DIV > 1) ? $clog2(INTGRL_DIV) : 1;
    localparam logic [IW-1:0]  INT_LAST = IW'(INTGRL_DIV - 1);

    state_t        state;
    state_t        nxt;
    ctrl_t         ctrl;
    logic [2:0]    idx;
    logic [IW-1:0] int_cnt;
    logic          int_last;
    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_exp;

    logic [15:0]   accum_r;
    logic [11:0]   error_r;
    logic [11:0]   intgrl_r;
    logic [11:0]   icomp_r;
    logic [15:0]   pcomp_r;
    logic [11:0]   lft_r;
    logic [11:0]   rht_r;

    assign int_last = (int_cnt == INT_LAST);

    ir_settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next state plus Moore decode of the ALU control word
    always_comb begin
        nxt          = state;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        ctrl.src1sel = SRC1_ZERO;
        ctrl.src0sel = SRC0_ZERO;
        ctrl.flags   = '0;
        ctrl.cap     = CAP_NONE;

        case (state)
            S_IDLE: begin
                if (bus.go) begin
                    tmr_load = 1'b1;
                    nxt      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_exp) nxt = S_CONV;
            end
            S_CONV: begin
                // A completion strobe here belongs to nothing we started; ignore it.
                nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.cnv_cmplt) nxt = S_ACC;
            end
            S_ACC: begin
                ctrl.src1sel = SRC1_ACCUM;
                ctrl.src0sel = SRC0_A2D;
                ctrl.cap     = CAP_ACCUM;
                // Outer pairs weigh 4x, middle 2x, inner 1x; left adds, right subtracts.
                case (idx)
                    3'd0: ctrl.src1sel = SRC1_ZERO;
                    3'd1: ctrl.flags[FLG_SUB] = 1'b1;
                    3'd2: ctrl.flags[FLG_MULT2] = 1'b1;
                    3'd3: begin
                        ctrl.flags[FLG_SUB]   = 1'b1;
                        ctrl.flags[FLG_MULT2] = 1'b1;
                    end
                    3'd4: ctrl.flags[FLG_MULT4] = 1'b1;
                    default: begin
                        ctrl.flags[FLG_SUB]   = 1'b1;
                        ctrl.flags[FLG_MULT4] = 1'b1;
                        ctrl.flags[FLG_SAT]   = 1'b1;
                        ctrl.cap              = CAP_ERROR;
                    end
                endcase
                if (idx == LAST_IDX) begin
                    nxt = int_last ? S_INTG : S_ICMP;
                end else begin
                    nxt = S_CONV;
                end
            end
            S_INTG: begin
                ctrl.src1sel        = SRC1_ERRSH4;
                ctrl.src0sel        = SRC0_INTGRL;
                ctrl.flags[FLG_SAT] = 1'b1;
                ctrl.cap            = CAP_INTGRL;
                nxt                 = S_ICMP;
            end
            S_ICMP: begin
                ctrl.src1sel             = SRC1_ITERM;
                ctrl.src0sel             = SRC0_INTGRL;
                ctrl.flags[FLG_MULTIPLY] = 1'b1;
                ctrl.cap                 = CAP_ICOMP;
                nxt                      = S_PCMP;
            end
            S_PCMP: begin
                ctrl.src1sel             = SRC1_ERROR;
                ctrl.src0sel             = SRC0_PTERM;
                ctrl.flags[FLG_MULTIPLY] = 1'b1;
                ctrl.cap                 = CAP_PCOMP;
                nxt                      = S_RHT1;
            end
            S_RHT1: begin
                ctrl.src1sel        = SRC1_FWD;
                ctrl.src0sel        = SRC0_PCOMP;
                ctrl.flags[FLG_SUB] = 1'b1;
                ctrl.cap            = CAP_ACCUM;
                nxt                 = S_RHT2;
            end
            S_RHT2: begin
                ctrl.src1sel        = SRC1_ACCUM;
                ctrl.src0sel        = SRC0_ICOMP;
                ctrl.flags[FLG_SUB] = 1'b1;
                ctrl.flags[FLG_SAT] = 1'b1;
                ctrl.cap            = CAP_RHT;
                nxt                 = S_LFT1;
            end
            S_LFT1: begin
                ctrl.src1sel = SRC1_FWD;
                ctrl.src0sel = SRC0_PCOMP;
                ctrl.cap     = CAP_ACCUM;
                nxt          = S_LFT2;
            end
            S_LFT2: begin
                ctrl.src1sel        = SRC1_ACCUM;
                ctrl.src0sel        = SRC0_ICOMP;
                ctrl.flags[FLG_SAT] = 1'b1;
                ctrl.cap            = CAP_LFT;
                nxt                 = S_DONE;
            end
            S_DONE: begin
                nxt = S_IDLE;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: capture dst into whichever register this state targets.
    always_ff @(posedge clk) begin
        if (rst) begin
            accum_r  <= '0;
            error_r  <= '0;
            intgrl_r <= '0;
            icomp_r  <= '0;
            pcomp_r  <= '0;
            lft_r    <= '0;
            rht_r    <= '0;
            idx      <= '0;
            int_cnt  <= '0;
        end else begin
            case (ctrl.cap)
                CAP_ACCUM:  accum_r  <= bus.dst;
                CAP_ERROR:  error_r  <= bus.dst[11:0];
                CAP_INTGRL: intgrl_r <= bus.dst[11:0];
                CAP_ICOMP:  icomp_r  <= bus.dst[11:0];
                CAP_PCOMP:  pcomp_r  <= bus.dst;
                CAP_RHT:    rht_r    <= bus.dst[11:0];
                CAP_LFT:    lft_r    <= bus.dst[11:0];
                default: ;
            endcase

            if (state == S_ACC) begin
                idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            end

            // The integrator decimation count advances once per go, at the
            // point where the INTG-or-skip decision is made.
            if ((state == S_ACC) && (idx == LAST_IDX)) begin
                int_cnt <= int_last ? '0 : int_cnt + 1'b1;
            end
        end
    end

    // Channel select is only driven while a conversion is outstanding, so it
    // reads 0 at rest and stays fixed from strt_cnv until cnv_cmplt.
    assign bus.chnnl    = ((state == S_CONV) || (state == S_WAIT)) ? chnl_map(idx) : 3'd0;
    assign bus.strt_cnv = (state == S_CONV);
    assign bus.ir_en    = (state == S_SETTLE) || (state == S_CONV) ||
                          (state == S_WAIT)   || (state == S_ACC);
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);

    assign bus.src1sel  = ctrl.src1sel;
    assign bus.src0sel  = ctrl.src0sel;
    assign bus.multiply = ctrl.flags[FLG_MULTIPLY];
    assign bus.sub      = ctrl.flags[FLG_SUB];
    assign bus.mult2    = ctrl.flags[FLG_MULT2];
    assign bus.mult4    = ctrl.flags[FLG_MULT4];
    assign bus.saturate = ctrl.flags[FLG_SAT];

    assign bus.Accum    = accum_r;
    assign bus.Error    = error_r;
    assign bus.Intgrl   = intgrl_r;
    assign bus.Icomp    = icomp_r;
    assign bus.Pcomp    = pcomp_r;
    assign bus.lft      = lft_r;
    assign bus.rht      = rht_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and A2D around the DUT,
// go-issuing stimulus pushes expected results, a done monitor pops and compares.
module tb_alu_sequencer;
    import line_follower_pkg::*;

    localparam int SETTLE  = 64;
    localparam int DIV     = 4;
    localparam int A2D_DLY = 3;
    localparam int LIMIT   = SETTLE + 400;

    localparam logic [15:0] FWD   = 16'h0400;
    localparam logic [15:0] PTERM = 16'h1000;
    localparam logic [15:0] ITERM = 16'h0000;

    typedef struct packed {
        logic [11:0] err;
        logic [15:0] pcomp;
        logic [11:0] intgrl;
        logic [11:0] rht;
        logic [11:0] lft;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] a2d_res = 12'h000;
    logic [11:0] chan_val [8];
    logic [2:0]  ch_order [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    exp_t        exp_q [$];
    int          errors   = 0;
    int          checks   = 0;
    int          done_cnt = 0;
    bit          glitch_conv = 1'b0;

    alu_sequencer_if bus ();

    alu_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .INTGRL_DIV    (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural line-follower ALU
    logic [15:0]        s1, s0, s0s, raw, res;
    logic signed [31:0] prod;
    always_comb begin
        case (bus.src1sel)
            3'd0:    s1 = bus.Accum;
            3'd1:    s1 = ITERM;
            3'd2:    s1 = {{4{bus.Error[11]}}, bus.Error};
            3'd3:    s1 = {{8{bus.Error[11]}}, bus.Error[11:4]};
            3'd4:    s1 = FWD;
            default: s1 = 16'h0000;
        endcase
        case (bus.src0sel)
            3'd0:    s0 = {4'h0, a2d_res};
            3'd1:    s0 = {{4{bus.Intgrl[11]}}, bus.Intgrl};
            3'd2:    s0 = {{4{bus.Icomp[11]}}, bus.Icomp};
            3'd3:    s0 = bus.Pcomp;
            3'd4:    s0 = PTERM;
            default: s0 = 16'h0000;
        endcase
        s0s  = bus.mult4 ? {s0[13:0], 2'b00} : (bus.mult2 ? {s0[14:0], 1'b0} : s0);
        prod = $signed(s1) * $signed(s0);
        if (bus.multiply)  raw = prod[27:12];
        else if (bus.sub)  raw = s1 - s0s;
        else               raw = s1 + s0s;
        res = raw;
        if (bus.saturate) begin
            if (!raw[15] && (raw > 16'h07FF))      res = 16'h07FF;
            else if (raw[15] && (raw < 16'hF800))  res = 16'hF800;
        end
        bus.dst = res;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural A2D: answers each strt_cnv A2D_DLY edges later and holds
    // its result; optionally fires a bogus completion during CONV.
    initial begin
        int         conv_idx;
        logic [2:0] ch;
        conv_idx = 0;
        bus.cnv_cmplt = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus.ir_en) conv_idx = 0;
            if (bus.strt_cnv) begin
                ch = bus.chnnl;
                check("chnnl_order", ch, ch_order[conv_idx]);
                conv_idx = (conv_idx + 1) % 6;
                if (glitch_conv) begin
                    a2d_res = 12'hABC;
                    bus.cnv_cmplt = 1'b1;
                    @(posedge clk);
                    #1 bus.cnv_cmplt = 1'b0;
                    repeat (A2D_DLY - 1) @(posedge clk);
                end else begin
                    repeat (A2D_DLY) @(posedge clk);
                end
                #1;
                a2d_res = chan_val[ch];
                bus.cnv_cmplt = 1'b1;
                if (bus.busy) check("chnnl_hold", bus.chnnl, ch);
                @(posedge clk);
                #1 bus.cnv_cmplt = 1'b0;
            end
        end
    end

    // Done monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                check("done_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("Error",  bus.Error,  e.err);
                    check("Pcomp",  bus.Pcomp,  e.pcomp);
                    check("Intgrl", bus.Intgrl, e.intgrl);
                    check("rht",    bus.rht,    e.rht);
                    check("lft",    bus.lft,    e.lft);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.go = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_chans(input logic [11:0] v);
        for (int i = 0; i < 8; i++) chan_val[i] = v;
    endtask

    task automatic pulse_go();
        @(posedge clk);
        #1 bus.go = 1'b1;
        @(posedge clk);
        #1 bus.go = 1'b0;
    endtask

    // One full go; returns cycles until done and cycles of IR settle.
    task automatic run_go(input exp_t e, output int lat, output int settle);
        bit seen_cnv;
        exp_q.push_back(e);
        pulse_go();
        lat = 0;
        settle = 0;
        seen_cnv = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.strt_cnv) seen_cnv = 1'b1;
            if (!seen_cnv && bus.ir_en) settle++;
        end while (!bus.done && lat < LIMIT);
        check("done_within_budget", bus.done, 1'b1);
        @(posedge clk);
        #1 check("busy_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat0, lat_t1, settle, n, cyc, d0;
        int   lat4 [4];
        exp_t e_t2;
        e_t2 = '{err: 12'h100, pcomp: 16'h0100, intgrl: 12'h000, rht: 12'h300, lft: 12'h500};
        bus.go = 1'b0;
        set_chans(12'h000);

        // Reset state
        do_reset();
        check("rst_busy",     bus.busy, 1'b0);
        check("rst_done",     bus.done, 1'b0);
        check("rst_strt_cnv", bus.strt_cnv, 1'b0);
        check("rst_ir_en",    bus.ir_en, 1'b0);
        check("rst_chnnl",    bus.chnnl, 3'd0);
        check("rst_src1sel",  bus.src1sel, 3'b111);
        check("rst_src0sel",  bus.src0sel, 3'b111);
        check("rst_flags",    {bus.multiply, bus.sub, bus.mult2, bus.mult4, bus.saturate}, 5'b0);
        check("rst_regs",     {bus.Accum, bus.Error, bus.lft, bus.rht}, 52'h0);

        // All channels equal -> balanced, straight ahead
        set_chans(12'h100);
        run_go('{err: 12'h000, pcomp: 16'h0000, intgrl: 12'h000, rht: 12'h400, lft: 12'h400},
               lat_t1, settle);
        check("settle_cycles", settle, SETTLE);

        // Only innermost left sensor lit; bogus completion during each CONV
        do_reset();
        set_chans(12'h000);
        chan_val[1] = 12'h100;
        glitch_conv = 1'b1;
        run_go(e_t2, lat0, settle);
        glitch_conv = 1'b0;

        // Outer right sensor saturated -> Error and rht clip
        do_reset();
        set_chans(12'h000);
        chan_val[7] = 12'hFFF;
        run_go('{err: 12'h800, pcomp: 16'hF800, intgrl: 12'h000, rht: 12'h7FF, lft: 12'hC00},
               lat0, settle);

        // Decimated integrator over four gos
        do_reset();
        set_chans(12'h000);
        chan_val[1] = 12'h100;
        for (int g = 0; g < 4; g++) begin
            exp_t e;
            e = e_t2;
            e.intgrl = (g == 3) ? 12'h010 : 12'h000;
            run_go(e, lat4[g], settle);
        end
        check("lat_go1_vs_first", lat4[0], lat_t1);
        check("lat_go2",          lat4[1], lat4[0]);
        check("lat_go3",          lat4[2], lat4[0]);
        check("lat_go4_plus1",    lat4[3], lat4[0] + 1);

        // go while busy and during DONE must not start another cycle
        d0 = done_cnt;
        e_t2.intgrl = 12'h010;
        exp_q.push_back(e_t2);
        pulse_go();
        repeat (20) @(posedge clk);
        #1 bus.go = 1'b1;
        @(posedge clk);
        #1 bus.go = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < LIMIT);
        check("done_seen_busy_go", bus.done, 1'b1);
        bus.go = 1'b1;
        @(posedge clk);
        #1 bus.go = 1'b0;
        check("busy_after_done_go", bus.busy, 1'b0);
        repeat (SETTLE + 150) @(posedge clk);
        check("one_done_only", done_cnt, d0 + 1);

        // Reset during WAIT of sensor 3, then restart from sensor 0
        pulse_go();
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (bus.strt_cnv) n++;
        end
        check("reach_idx3_conv", n, 4);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy",     bus.busy, 1'b0);
        check("midrst_strt_cnv", bus.strt_cnv, 1'b0);
        check("midrst_ir_en",    bus.ir_en, 1'b0);
        check("midrst_src_sel",  {bus.src1sel, bus.src0sel}, 6'b111111);
        check("midrst_Accum",    bus.Accum, 16'h0000);
        check("midrst_Error",    bus.Error, 12'h000);
        check("midrst_Intgrl",   bus.Intgrl, 12'h000);
        check("midrst_lft_rht",  {bus.lft, bus.rht}, 24'h0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        e_t2.intgrl = 12'h000;
        run_go(e_t2, lat0, settle);
        check("restart_latency", lat0, lat_t1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
